fpu_sequencer: RTL
==================

FPU_SEQUENCER -- requirements
Module: fpu_sequencer

Interface
REQ-001 Parameter TAG_W, default 4, width of the request/response tag.
REQ-002 Parameter TIMEOUT, default 64, maximum WAIT cycles before an operation is abandoned.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  requester presents an operation.
REQ-006 req_ready  output  1  sequencer accepts the operation this cycle.
REQ-007 req_funct  input  2  0 add, 1 subtract, 2 divide, 3 multiply.
REQ-008 req_a, req_b  input  32 each  IEEE-754 single-precision operands.
REQ-009 req_tag  input  TAG_W  requester tag, returned with the result.
REQ-010 fpu_funct  output  2  function select driven to the FPU datapath.
REQ-011 fpu_a, fpu_b  output  32 each  operands driven to the FPU datapath.
REQ-012 fpu_start  output  1  one-cycle pulse marking operation launch.
REQ-013 fpu_o  input  32  FPU result.
REQ-014 fpu_finish  input  1  FPU finish flag for the selected function.
REQ-015 resp_valid  output  1  result available.
REQ-016 resp_ready  input  1  consumer takes the result.
REQ-017 resp_o  output  32  captured result.
REQ-018 resp_tag  output  TAG_W  tag of the completed operation.
REQ-019 resp_timeout  output  1  operation abandoned; resp_o holds the timeout value.
REQ-020 busy  output  1  high in every state except IDLE.

Function
REQ-021 FSM states are IDLE, ISSUE, WAIT and RESP, and the FSM holds exactly one operation in flight.
REQ-022 req_ready = 1 only in IDLE; a handshake (req_valid & req_ready) latches funct, a, b and tag, then moves to ISSUE.
REQ-023 ISSUE lasts one cycle: fpu_start = 1, then moves to WAIT.
REQ-024 fpu_funct, fpu_a and fpu_b are driven from the latched registers and stay stable in ISSUE and WAIT.
REQ-025 In every other state, fpu_funct, fpu_a and fpu_b hold their last values.
REQ-026 fpu_finish is ignored during ISSUE to reject a stale finish from the prior operation.
REQ-027 In WAIT, fpu_finish = 1 latches fpu_o into resp_o, sets resp_timeout = 0 and moves to RESP.
REQ-028 The WAIT cycle counter clears on entry to WAIT and increments each WAIT cycle without finish.
REQ-029 When the counter reaches TIMEOUT-1 without finish: resp_o = 32'h7FC00000 (qNaN), resp_timeout = 1, move to RESP.
REQ-030 fpu_finish and the timeout in the same cycle: finish wins, resp_timeout = 0.
REQ-031 Latency: handshake at cycle N, fpu_start at N+1, earliest resp_valid at N+3.
REQ-032 In RESP, resp_valid = 1, and resp_o, resp_tag and resp_timeout hold stable until resp_ready = 1.
REQ-033 On resp_ready = 1 in RESP, move to IDLE; a new request is not accepted in that same cycle.
REQ-034 req_valid is ignored in all states other than IDLE, and the requester holds it.
REQ-035 The counter is sized to hold values up to TIMEOUT-1 (clog2(TIMEOUT) bits), with no wrap-around before timeout.

Reset
REQ-036 rst forces IDLE in any state, including mid-WAIT; the in-flight operation is dropped with no response.
REQ-037 Reset values: req_ready 0 during rst then 1 in IDLE; fpu_start 0, resp_valid 0, resp_timeout 0, busy 0.
REQ-038 Reset values: resp_o, resp_tag, fpu_a and fpu_b are 0; fpu_funct is 0; the counter is 0.

Structure
REQ-039 A shared package fpu_pkg holds the FSM state enum, the funct encoding constants (FN_ADD, FN_SUB, FN_DIV, FN_MUL) and the QNAN constant 32'h7FC00000.
REQ-040 One sub-module, fpu_timeout_cnt, implements the clear/enable counter with a terminal-count output; everything else is in fpu_sequencer.

Verification
REQ-041 Multiply: a=3F800000, b=40000000, funct 3, model finish after 5 cycles with o=40000000 -> resp_o=40000000, tag echoed, resp_timeout=0.
REQ-042 Finish never asserted, TIMEOUT=8 -> resp_valid exactly 8 WAIT cycles after entering WAIT, resp_o=7FC00000, resp_timeout=1.
REQ-043 fpu_finish held high during ISSUE, then low for 3 cycles, then high -> response captured only on the WAIT finish.
REQ-044 resp_ready held low for 10 cycles -> resp_valid, resp_o and resp_tag stable all 10 cycles; req_ready=0 throughout.
REQ-045 rst asserted on the 2nd WAIT cycle -> next cycle IDLE, busy=0, resp_valid never asserts for that operation.
REQ-046 Back-to-back requests with tags 1 and 2 -> two responses in order, the second fpu_start at least 2 cycles after the first response is taken.

Source files
------------

// File: rtl/fpu_pkg.sv
// FPU sequencer shared types and constants.
// FSM states, function encodings and the timeout result value.
package fpu_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] FN_ADD = 2'd0;
  localparam logic [1:0] FN_SUB = 2'd1;
  localparam logic [1:0] FN_DIV = 2'd2;
  localparam logic [1:0] FN_MUL = 2'd3;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fpu_timeout_cnt.sv
// WAIT-cycle counter with clear, enable and terminal count.
// Saturates at LIMIT-1 so it can never wrap before timeout.
module fpu_timeout_cnt #(
  parameter int unsigned LIMIT = 64,
  localparam int unsigned CW = (LIMIT > 1) ? $clog2(LIMIT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fpu_sequencer.sv
// Single-operation FPU sequencer: accept, launch, wait, respond.
// A stuck FPU is abandoned after TIMEOUT WAIT cycles with a qNaN.
module fpu_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_funct,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [1:0]       fpu_funct,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic             fpu_start,
  input  logic [31:0]      fpu_o,
  input  logic             fpu_finish,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_o,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_timeout,
  output logic             busy
);

  state_e state_q, state_d;

  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_tc;
  logic             cap_res;
  logic             cap_to;
  logic             hs;

  logic [1:0]       funct_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      res_q;
  logic             to_q;

  fpu_timeout_cnt #(
    .LIMIT (TIMEOUT)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (cnt_tc)
  );

  assign req_ready    = (state_q == S_IDLE) && !rst;
  assign hs           = req_valid && req_ready;
  assign fpu_start    = (state_q == S_ISSUE);
  assign resp_valid   = (state_q == S_RESP);
  assign busy         = (state_q != S_IDLE);
  assign fpu_funct    = funct_q;
  assign fpu_a        = a_q;
  assign fpu_b        = b_q;
  assign resp_o       = res_q;
  assign resp_tag     = tag_q;
  assign resp_timeout = to_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Finish is only looked at in WAIT, so a stale one in ISSUE is dropped
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    cap_res = 1'b0;
    cap_to  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (hs) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cnt_clr = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fpu_finish) begin
          cap_res = 1'b1;
          state_d = S_RESP;
        end else if (cnt_tc) begin
          cap_to  = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_en  = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      funct_q <= FN_ADD;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      if (hs) begin
        funct_q <= req_funct;
        a_q     <= req_a;
        b_q     <= req_b;
        tag_q   <= req_tag;
      end
      if (cap_res) begin
        res_q <= fpu_o;
        to_q  <= 1'b0;
      end else if (cap_to) begin
        res_q <= QNAN;
        to_q  <= 1'b1;
      end
    end
  end

endmodule
